// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button front end: channel indices and the per-channel press FSM encoding.
package button_conditioner_pkg;

    localparam int unsigned NUM_BUTTONS = 7;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_START = 4;
    localparam int unsigned BTN_A     = 5;
    localparam int unsigned BTN_B     = 6;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'b00,
        ST_IDLE   = 2'b01,
        ST_HELD   = 2'b10,
        ST_REPEAT = 2'b11
    } btn_state_t;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchronizer, stability-counter debouncer and press/auto-repeat FSM.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed,
    output logic held,
    output logic pulse
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_SAT    = {RW{1'b1}};
    localparam bit            DO_REPEAT   = REPEAT_EN && (REPEAT_DELAY != 0);

    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          held_q, held_d;
    btn_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          pulse_q, pulse_d;
    logic          rise_c, fall_c;

    // State register; held resets to pressed so a button down at reset stays locked out.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b00;
            db_cnt_q <= '0;
            held_q   <= 1'b1;
            state_q  <= ST_LOCKED;
            rcnt_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], pressed};
            db_cnt_q <= db_cnt_d;
            held_q   <= held_d;
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Debouncer and FSM act on the same edge, so the pulse lines up with the held transition.
    always_comb begin
        db_cnt_d = '0;
        held_d   = held_q;
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        pulse_d  = 1'b0;

        if (sync_q[1] != held_q) begin
            if (db_cnt_q == DB_LAST) begin
                held_d = ~held_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end

        rise_c = held_d & ~held_q;
        fall_c = ~held_d & held_q;

        case (state_q)
            ST_LOCKED: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                rcnt_d = '0;
                if (rise_c) begin
                    pulse_d = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (DO_REPEAT && (rcnt_q == DELAY_LAST)) begin
                    pulse_d = 1'b1;
                    state_d = ST_REPEAT;
                    rcnt_d  = '0;
                end else if (rcnt_q != RCNT_SAT) begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            ST_REPEAT: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == PERIOD_LAST) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: begin
                state_d = ST_LOCKED;
                rcnt_d  = '0;
            end
        endcase
    end

    assign held  = held_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: polarity normalization, seven independent conditioning channels, named pulse outputs.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned               DEBOUNCE_CYCLES = 500000,
    parameter int unsigned               REPEAT_DELAY    = 25000000,
    parameter int unsigned               REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_BUTTONS-1:0]    REPEAT_MASK     = 7'b0001111,
    parameter bit                        ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] raw_buttons,
    output logic                   up_button,
    output logic                   down_button,
    output logic                   left_button,
    output logic                   right_button,
    output logic                   start_button,
    output logic                   a_button,
    output logic                   b_button,
    output logic [NUM_BUTTONS-1:0] held
);

    logic [NUM_BUTTONS-1:0] pressed_c;
    logic [NUM_BUTTONS-1:0] pulses;

    assign pressed_c = ACTIVE_LOW ? ~raw_buttons : raw_buttons;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .pressed (pressed_c[i]),
            .held    (held[i]),
            .pulse   (pulses[i])
        );
    end

    assign up_button    = pulses[BTN_UP];
    assign down_button  = pulses[BTN_DOWN];
    assign left_button  = pulses[BTN_LEFT];
    assign right_button = pulses[BTN_RIGHT];
    assign start_button = pulses[BTN_START];
    assign a_button     = pulses[BTN_A];
    assign b_button     = pulses[BTN_B];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses queued at stimulus time, checked every cycle by a monitor.
module tb_button_conditioner;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] raw;
    logic       up_button, down_button, left_button, right_button;
    logic       start_button, a_button, b_button;
    logic [6:0] held;
    logic [6:0] pulses_obs;

    int unsigned cyc = 0;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    bit          done = 1'b0;
    exp_t        exp_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .REPEAT_MASK     (7'b0001111),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_buttons  (raw),
        .up_button    (up_button),
        .down_button  (down_button),
        .left_button  (left_button),
        .right_button (right_button),
        .start_button (start_button),
        .a_button     (a_button),
        .b_button     (b_button),
        .held         (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign pulses_obs = {b_button, a_button, start_button, right_button,
                         left_button, down_button, up_button};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int unsigned c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Scoreboard monitor: the pulse bus must match the queue head on its cycle and be zero otherwise.
    always @(negedge clk) begin
        if (!done) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("pulse_at_%0d", cyc), 32'(pulses_obs), 32'(e.vec));
            end else begin
                chk($sformatf("no_pulse_at_%0d", cyc), 32'(pulses_obs), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned m;
        int unsigned rel;
        int unsigned c;

        raw   = 7'h7F;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_in_reset", 32'(held), 32'h7F);

        // Release from reset with all buttons up
        reset = 1'b0;
        rel   = cyc;
        wait_cyc(rel + 3);
        chk("held_before_debounce", 32'(held), 32'h7F);
        wait_cyc(rel + 6);
        chk("held_after_debounce", 32'(held), 32'h00);
        wait_cyc(rel + 10);

        // a: single press, not repeat-eligible
        raw[5] = 1'b0;
        n = cyc + 1;
        push(n + 5, 7'b0100000);
        wait_cyc(n + 4);
        chk("a_held_pre", 32'(held[5]), 32'h0);
        wait_cyc(n + 5);
        chk("a_held_rise", 32'(held[5]), 32'h1);
        wait_cyc(n + 39);
        raw[5] = 1'b1;
        m = cyc + 1;
        wait_cyc(m + 4);
        chk("a_held_pre_fall", 32'(held[5]), 32'h1);
        wait_cyc(m + 5);
        chk("a_held_fall", 32'(held[5]), 32'h0);
        wait_cyc(m + 10);

        // up: auto-repeat, release suppresses the pulse maturing on the fall edge
        raw[0] = 1'b0;
        n = cyc + 1;
        push(n + 5,  7'b0000001);
        push(n + 15, 7'b0000001);
        push(n + 20, 7'b0000001);
        push(n + 25, 7'b0000001);
        push(n + 30, 7'b0000001);
        wait_cyc(n + 29);
        raw[0] = 1'b1;
        m = cyc + 1;
        wait_cyc(m + 4);
        chk("up_held_pre_fall", 32'(held[0]), 32'h1);
        wait_cyc(m + 5);
        chk("up_held_fall", 32'(held[0]), 32'h0);
        wait_cyc(m + 10);

        // start: 3-cycle glitch is rejected
        raw[4] = 1'b0;
        n = cyc + 1;
        wait_cyc(n + 2);
        raw[4] = 1'b1;
        wait_cyc(n + 4);
        chk("start_glitch_a", 32'(held[4]), 32'h0);
        wait_cyc(n + 5);
        chk("start_glitch_b", 32'(held[4]), 32'h0);
        wait_cyc(n + 8);
        chk("start_glitch_c", 32'(held[4]), 32'h0);
        wait_cyc(n + 12);

        // left and b together
        raw[2] = 1'b0;
        raw[6] = 1'b0;
        n = cyc + 1;
        push(n + 5, 7'b1000100);
        wait_cyc(n + 5);
        chk("left_b_held", 32'(held), 32'h44);
        wait_cyc(n + 7);
        raw[2] = 1'b1;
        raw[6] = 1'b1;
        m = cyc + 1;
        wait_cyc(m + 6);
        chk("left_b_released", 32'(held), 32'h00);
        wait_cyc(m + 10);

        // down held across a reset: locked out until released and pressed again
        raw[1] = 1'b0;
        n = cyc + 1;
        push(n + 5, 7'b0000010);
        wait_cyc(n + 5);
        chk("down_held", 32'(held), 32'h02);
        wait_cyc(n + 8);
        reset = 1'b1;
        c = cyc;
        wait_cyc(c + 1);
        chk("held_mid_reset", 32'(held), 32'h7F);
        wait_cyc(c + 2);
        reset = 1'b0;
        rel = cyc;
        wait_cyc(rel + 6);
        chk("held_after_mid_reset", 32'(held), 32'h02);
        wait_cyc(rel + 30);
        chk("down_still_held", 32'(held[1]), 32'h1);
        raw[1] = 1'b1;
        m = cyc + 1;
        wait_cyc(m + 5);
        chk("down_released", 32'(held[1]), 32'h0);
        wait_cyc(m + 8);
        raw[1] = 1'b0;
        n = cyc + 1;
        push(n + 5, 7'b0000010);
        wait_cyc(n + 7);
        raw[1] = 1'b1;
        m = cyc + 1;
        wait_cyc(m + 10);
        chk("down_final_held", 32'(held), 32'h00);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
